icache_fill_sequencer: RTL

// - Write-side companion of the vanilla-core icache: on a miss, fetches one icache block from memory and writes it back in order.
// - Issues one word-read request per block word, accepts responses in any order, and buffers them by block offset.
// - Drives the icache write port (v/w/w_pc/w_instr) strictly in block-offset order 0..N-1, as the icache's write buffer requires.

---
 rtl/icache_fill_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/icache_fill_sequencer.sv
// Icache block fill sequencer: issues one word read per block word, reorders the responses
// by block offset and writes them into the icache strictly in offset order.
module icache_fill_sequencer #(
  parameter int unsigned icache_tag_width_p           = 4,
  parameter int unsigned icache_entries_p             = 256,
  parameter int unsigned icache_block_size_in_words_p = 4,
  localparam int unsigned pc_width_lp = icache_tag_width_p + $clog2(icache_entries_p),
  localparam int unsigned block_offset_width_lp =
      (icache_block_size_in_words_p > 1) ? $clog2(icache_block_size_in_words_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             miss_v_i,
  input  logic [pc_width_lp-1:0]           miss_pc_i,
  output logic                             miss_ready_o,
  output logic                             req_v_o,
  output logic [pc_width_lp-1:0]           req_addr_o,
  input  logic                             req_ready_i,
  input  logic                             resp_v_i,
  input  logic [block_offset_width_lp-1:0] resp_offset_i,
  input  logic [31:0]                      resp_data_i,
  input  logic                             icache_w_ready_i,
  output logic                             icache_v_o,
  output logic                             icache_w_o,
  output logic [pc_width_lp-1:0]           icache_w_pc_o,
  output logic [31:0]                      icache_w_instr_o,
  output logic                             fill_done_o,
  output logic                             err_r_o
);

  localparam int unsigned block_words_lp = icache_block_size_in_words_p;
  localparam logic [block_offset_width_lp-1:0] last_off_lp =
      block_offset_width_lp'(block_words_lp - 1);
  localparam logic [pc_width_lp-1:0] off_mask_lp = pc_width_lp'(block_words_lp - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                           r_state, w_state_next;
  logic [pc_width_lp-1:0]           r_base;
  logic [block_offset_width_lp-1:0] r_req_cnt, r_wr_cnt;
  logic [31:0]                      r_buf [block_words_lp];
  logic [block_words_lp-1:0]        r_vld;
  logic                             r_err;

  logic                      w_active, w_req_hs, w_wr, w_off_ok, w_cap, w_drop;
  logic                      w_miss_acc;
  logic [block_words_lp-1:0] w_vld_set, w_vld_clr;

  // Counters wrap at N; with N==1 they stay at zero.
  function automatic logic [block_offset_width_lp-1:0] f_inc(
    input logic [block_offset_width_lp-1:0] cnt
  );
    return (cnt == last_off_lp) ? '0 : cnt + 1'b1;
  endfunction

  assign w_active   = (r_state == StReq) || (r_state == StWait);
  assign w_miss_acc = (r_state == StIdle) && miss_v_i;
  assign w_req_hs   = (r_state == StReq) && req_ready_i;
  assign w_wr       = w_active && r_vld[r_wr_cnt] && icache_w_ready_i;
  assign w_off_ok   = 32'(resp_offset_i) < block_words_lp;
  // A response into an occupied slot or outside a fill is dropped and flagged.
  assign w_cap      = resp_v_i && w_active && w_off_ok && !r_vld[resp_offset_i];
  assign w_drop     = resp_v_i && !w_cap;

  always_comb begin
    w_vld_set = '0;
    w_vld_clr = '0;
    if (w_cap) w_vld_set[resp_offset_i] = 1'b1;
    if (w_wr)  w_vld_clr[r_wr_cnt]      = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (miss_v_i) w_state_next = StReq;
      StReq: begin
        if (w_wr && (r_wr_cnt == last_off_lp)) begin
          w_state_next = StDone;
        end else if (w_req_hs && (r_req_cnt == last_off_lp)) begin
          w_state_next = StWait;
        end
      end
      StWait: if (w_wr && (r_wr_cnt == last_off_lp)) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= StIdle;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_wr_cnt  <= '0;
      r_vld     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_vld   <= (r_vld | w_vld_set) & ~w_vld_clr;
      if (w_drop) r_err <= 1'b1;
      if (w_miss_acc) begin
        r_base    <= miss_pc_i & ~off_mask_lp;
        r_req_cnt <= '0;
        r_wr_cnt  <= '0;
      end else begin
        if (w_req_hs) r_req_cnt <= f_inc(r_req_cnt);
        if (w_wr)     r_wr_cnt  <= f_inc(r_wr_cnt);
      end
    end
  end

  // Data storage needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_cap) r_buf[resp_offset_i] <= resp_data_i;
  end

  assign miss_ready_o     = (r_state == StIdle);
  assign req_v_o          = (r_state == StReq);
  assign req_addr_o       = req_v_o ? (r_base | pc_width_lp'(r_req_cnt)) : '0;
  assign icache_v_o       = w_wr;
  assign icache_w_o       = w_wr;
  assign icache_w_pc_o    = w_wr ? (r_base | pc_width_lp'(r_wr_cnt)) : '0;
  assign icache_w_instr_o = w_wr ? r_buf[r_wr_cnt] : '0;
  assign fill_done_o      = (r_state == StDone);
  assign err_r_o          = r_err;

endmodule
